button_press_classifier: RTL and testbench

Turns the debounced press/release strobes from the button debouncer into user-level gestures:
- short press
- long press, with auto-repeat while held
- double press

It sits directly downstream of the debouncer and upstream of the control/menu logic, which consumes only single-cycle gesture pulses. The button is active-low, so a debouncer "down" strobe is a press and an "up" strobe is a release.

---
 rtl/btn_pkg.sv | 24 ++
 rtl/tick_counter.sv | 26 ++
 rtl/button_press_classifier.sv | 163 ++++++++++++++++
 tb/tb_button_press_classifier.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default timing for the button gesture classifier.
package btn_pkg;

    // Classifier FSM states; the encoding is visible on state_o for debug.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESSED  = 3'd1,
        HELD     = 3'd2,
        WAIT_GAP = 3'd3,
        SECOND   = 3'd4
    } btn_state_t;

    // Default tick counts for a 12 MHz board clock.
    localparam int DEFAULT_CNT_WIDTH    = 24;
    localparam int DEFAULT_LONG_TICKS   = 12_000_000;  // 1.0 s
    localparam int DEFAULT_GAP_TICKS    = 6_000_000;   // 0.5 s
    localparam int DEFAULT_REPEAT_TICKS = 3_000_000;   // 0.25 s

    // True when a tick count is non-zero and fits in a counter of the given width.
    function automatic bit ticks_in_range(input longint ticks, input int width);
        return (ticks >= 1) && (ticks <= ((longint'(1) << width) - 1));
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Free-running up-counter with synchronous clear and an equality flag
// against a limit that the owner may change from cycle to cycle.
module tick_counter #(
    parameter int CNT_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 clear,
    input  logic [CNT_WIDTH-1:0] limit,
    output logic                 hit
);

    logic [CNT_WIDTH-1:0] count;

    // Count up every cycle; clear or reset forces the count back to zero.
    always_ff @(posedge clk) begin
        if (!arst_n || clear) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == limit);

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced press/release strobes into short, long, repeat and
// double press gestures, each delivered as a registered one-cycle pulse.
module button_press_classifier
    import btn_pkg::*;
#(
    parameter int CNT_WIDTH    = DEFAULT_CNT_WIDTH,
    parameter int LONG_TICKS   = DEFAULT_LONG_TICKS,
    parameter int GAP_TICKS    = DEFAULT_GAP_TICKS,
    parameter int REPEAT_TICKS = DEFAULT_REPEAT_TICKS
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       sw_down_i,
    input  logic       sw_up_i,
    output logic       short_press_o,
    output logic       long_press_o,
    output logic       repeat_o,
    output logic       double_press_o,
    output logic       hold_o,
    output logic [2:0] state_o
);

    // Refuse to elaborate with tick counts the counter cannot represent.
    if (!ticks_in_range(LONG_TICKS, CNT_WIDTH)) begin : g_bad_long
        $error("LONG_TICKS must be in 1 .. 2**CNT_WIDTH-1");
    end
    if (!ticks_in_range(GAP_TICKS, CNT_WIDTH)) begin : g_bad_gap
        $error("GAP_TICKS must be in 1 .. 2**CNT_WIDTH-1");
    end
    if (!ticks_in_range(REPEAT_TICKS, CNT_WIDTH)) begin : g_bad_repeat
        $error("REPEAT_TICKS must be in 1 .. 2**CNT_WIDTH-1");
    end

    // The counter starts at 0 on the edge that enters a state, so the
    // threshold test is against ticks-1 to land exactly ticks edges later.
    localparam logic [CNT_WIDTH-1:0] LONG_LIMIT   = CNT_WIDTH'(LONG_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LIMIT    = CNT_WIDTH'(GAP_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] REPEAT_LIMIT = CNT_WIDTH'(REPEAT_TICKS - 1);

    btn_state_t           state_q;
    btn_state_t           state_next;
    logic                 press_evt;
    logic                 release_evt;
    logic                 cnt_hit;
    logic                 cnt_clear;
    logic [CNT_WIDTH-1:0] cnt_limit;
    logic                 long_fire;
    logic                 repeat_fire;
    logic                 short_fire;
    logic                 double_fire;
    logic                 double_pending;

    // Simultaneous press and release strobes are contradictory and dropped.
    assign press_evt   = sw_down_i & ~sw_up_i;
    assign release_evt = sw_up_i & ~sw_down_i;

    // Pick the threshold that matters in the current state.
    always_comb begin
        cnt_limit = '0;
        unique case (state_q)
            PRESSED:  cnt_limit = LONG_LIMIT;
            HELD:     cnt_limit = REPEAT_LIMIT;
            WAIT_GAP: cnt_limit = GAP_LIMIT;
            default:  cnt_limit = '0;
        endcase
    end

    tick_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_tick_counter (
        .clk    (clk),
        .arst_n (arst_n),
        .clear  (cnt_clear),
        .limit  (cnt_limit),
        .hit    (cnt_hit)
    );

    // Next-state and gesture decisions; strobes are tested before the
    // counter so a strobe on a threshold edge always wins.
    always_comb begin
        state_next  = state_q;
        long_fire   = 1'b0;
        repeat_fire = 1'b0;
        short_fire  = 1'b0;
        double_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (press_evt) begin
                    state_next = PRESSED;
                end
            end
            PRESSED: begin
                if (release_evt) begin
                    state_next = WAIT_GAP;
                end else if (cnt_hit) begin
                    long_fire  = 1'b1;
                    state_next = HELD;
                end
            end
            HELD: begin
                if (release_evt) begin
                    state_next = IDLE;
                end else if (cnt_hit) begin
                    repeat_fire = 1'b1;
                end
            end
            WAIT_GAP: begin
                if (press_evt) begin
                    state_next = SECOND;
                end else if (cnt_hit) begin
                    short_fire = 1'b1;
                    state_next = IDLE;
                end
            end
            SECOND: begin
                if (release_evt) begin
                    double_fire = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Restart timing on every state change and every repeat tick; states
    // that do not time anything keep the counter parked at zero.
    assign cnt_clear = (state_next != state_q) || repeat_fire ||
                       (state_q == IDLE) || (state_q == SECOND);

    // State register.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Registered gesture pulses; the double press and the hold release are
    // delivered one edge after the release that caused them.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            short_press_o  <= 1'b0;
            long_press_o   <= 1'b0;
            repeat_o       <= 1'b0;
            double_pending <= 1'b0;
            double_press_o <= 1'b0;
            hold_o         <= 1'b0;
        end else begin
            short_press_o  <= short_fire;
            long_press_o   <= long_fire;
            repeat_o       <= repeat_fire;
            double_pending <= double_fire;
            double_press_o <= double_pending;
            hold_o         <= long_fire || (state_q == HELD);
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed self-checking bench for button_press_classifier with short timing.
module tb_button_press_classifier;

    localparam int LONG   = 20;
    localparam int GAP    = 10;
    localparam int REPEAT = 5;

    logic       clk;
    logic       arst_n;
    logic       sw_down_i;
    logic       sw_up_i;
    logic       short_press_o;
    logic       long_press_o;
    logic       repeat_o;
    logic       double_press_o;
    logic       hold_o;
    logic [2:0] state_o;

    int edge_cnt;
    int n_checks;
    int n_fail;
    int short_q[$];
    int long_q[$];
    int repeat_q[$];
    int double_q[$];
    int hold_rise_q[$];
    int hold_fall_q[$];
    logic hold_prev;

    button_press_classifier #(
        .CNT_WIDTH    (8),
        .LONG_TICKS   (LONG),
        .GAP_TICKS    (GAP),
        .REPEAT_TICKS (REPEAT)
    ) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .sw_down_i      (sw_down_i),
        .sw_up_i        (sw_up_i),
        .short_press_o  (short_press_o),
        .long_press_o   (long_press_o),
        .repeat_o       (repeat_o),
        .double_press_o (double_press_o),
        .hold_o         (hold_o),
        .state_o        (state_o)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number every rising edge so tests can talk in edge indices.
    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Log the edge index of every gesture pulse and hold_o transition.
    initial hold_prev = 1'b0;
    always @(posedge clk) begin
        #1;
        if (short_press_o)  short_q.push_back(edge_cnt);
        if (long_press_o)   long_q.push_back(edge_cnt);
        if (repeat_o)       repeat_q.push_back(edge_cnt);
        if (double_press_o) double_q.push_back(edge_cnt);
        if (hold_o && !hold_prev) hold_rise_q.push_back(edge_cnt);
        if (!hold_o && hold_prev) hold_fall_q.push_back(edge_cnt);
        hold_prev = hold_o;
    end

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int e);
        while (edge_cnt < e) step();
    endtask

    // Drive a one-cycle strobe so that it is sampled on edge t.
    task automatic strobe(input logic d, input logic u, input int t);
        while (edge_cnt < t - 1) step();
        sw_down_i = d;
        sw_up_i   = u;
        step();
        sw_down_i = 1'b0;
        sw_up_i   = 1'b0;
    endtask

    task automatic clear_log();
        short_q.delete();
        long_q.delete();
        repeat_q.delete();
        double_q.delete();
        hold_rise_q.delete();
        hold_fall_q.delete();
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        step();
        step();
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_state: got %0d, expected 0", state_o); end
        n_checks++; if (short_press_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_short: got %b, expected 0", short_press_o); end
        n_checks++; if (long_press_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_long: got %b, expected 0", long_press_o); end
        n_checks++; if (repeat_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_repeat: got %b, expected 0", repeat_o); end
        n_checks++; if (double_press_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_double: got %b, expected 0", double_press_o); end
        n_checks++; if (hold_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_hold: got %b, expected 0", hold_o); end
        arst_n = 1'b1;
        step();
    endtask

    task automatic test_short_press();
        int p;
        clear_log();
        p = edge_cnt + 2;
        strobe(1'b1, 1'b0, p);
        strobe(1'b0, 1'b1, p + 5);
        wait_until(p + 25);
        n_checks++; if (short_q.size() !== 1) begin n_fail++; $display("[TB] FAIL short_count: got %0d, expected 1", short_q.size()); end
        n_checks++; if (qat(short_q, 0) !== p + 15) begin n_fail++; $display("[TB] FAIL short_edge: got %0d, expected %0d", qat(short_q, 0), p + 15); end
        n_checks++; if (long_q.size() + repeat_q.size() + double_q.size() !== 0) begin n_fail++; $display("[TB] FAIL short_other_pulses: got %0d, expected 0", long_q.size() + repeat_q.size() + double_q.size()); end
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("[TB] FAIL short_end_state: got %0d, expected 0", state_o); end
    endtask

    task automatic test_long_repeat();
        int p;
        clear_log();
        p = edge_cnt + 2;
        strobe(1'b1, 1'b0, p);
        wait_until(p + 22);
        n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("[TB] FAIL long_state_held: got %0d, expected 2", state_o); end
        n_checks++; if (hold_o !== 1'b1) begin n_fail++; $display("[TB] FAIL long_hold_level: got %b, expected 1", hold_o); end
        // Release lands on the fourth repeat tick, which must be suppressed.
        strobe(1'b0, 1'b1, p + 40);
        wait_until(p + 60);
        n_checks++; if (long_q.size() !== 1) begin n_fail++; $display("[TB] FAIL long_count: got %0d, expected 1", long_q.size()); end
        n_checks++; if (qat(long_q, 0) !== p + 20) begin n_fail++; $display("[TB] FAIL long_edge: got %0d, expected %0d", qat(long_q, 0), p + 20); end
        n_checks++; if (repeat_q.size() !== 3) begin n_fail++; $display("[TB] FAIL repeat_count: got %0d, expected 3", repeat_q.size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (qat(repeat_q, i) !== p + 25 + 5 * i) begin n_fail++; $display("[TB] FAIL repeat_edge_%0d: got %0d, expected %0d", i, qat(repeat_q, i), p + 25 + 5 * i); end
        end
        n_checks++; if (qat(hold_rise_q, 0) !== p + 20) begin n_fail++; $display("[TB] FAIL hold_rise: got %0d, expected %0d", qat(hold_rise_q, 0), p + 20); end
        n_checks++; if (qat(hold_fall_q, 0) !== p + 41) begin n_fail++; $display("[TB] FAIL hold_fall: got %0d, expected %0d", qat(hold_fall_q, 0), p + 41); end
        n_checks++; if (short_q.size() + double_q.size() !== 0) begin n_fail++; $display("[TB] FAIL long_other_pulses: got %0d, expected 0", short_q.size() + double_q.size()); end
    endtask

    task automatic test_double_press();
        int p;
        clear_log();
        p = edge_cnt + 2;
        strobe(1'b1, 1'b0, p);
        strobe(1'b0, 1'b1, p + 3);
        strobe(1'b1, 1'b0, p + 7);
        strobe(1'b0, 1'b1, p + 9);
        wait_until(p + 30);
        n_checks++; if (double_q.size() !== 1) begin n_fail++; $display("[TB] FAIL double_count: got %0d, expected 1", double_q.size()); end
        n_checks++; if (qat(double_q, 0) !== p + 10) begin n_fail++; $display("[TB] FAIL double_edge: got %0d, expected %0d", qat(double_q, 0), p + 10); end
        n_checks++; if (short_q.size() + long_q.size() + repeat_q.size() !== 0) begin n_fail++; $display("[TB] FAIL double_other_pulses: got %0d, expected 0", short_q.size() + long_q.size() + repeat_q.size()); end
    endtask

    task automatic test_gap_boundary();
        int p;
        clear_log();
        p = edge_cnt + 2;
        strobe(1'b1, 1'b0, p);
        strobe(1'b0, 1'b1, p + 2);
        // Second press on the very edge the gap expires.
        strobe(1'b1, 1'b0, p + 12);
        strobe(1'b0, 1'b1, p + 14);
        wait_until(p + 30);
        n_checks++; if (short_q.size() !== 0) begin n_fail++; $display("[TB] FAIL gap_edge_short: got %0d, expected 0", short_q.size()); end
        n_checks++; if (qat(double_q, 0) !== p + 15) begin n_fail++; $display("[TB] FAIL gap_edge_double: got %0d, expected %0d", qat(double_q, 0), p + 15); end
    endtask

    task automatic test_long_boundary();
        int p;
        clear_log();
        p = edge_cnt + 2;
        strobe(1'b1, 1'b0, p);
        strobe(1'b0, 1'b1, p + 20);
        wait_until(p + 40);
        n_checks++; if (long_q.size() !== 0) begin n_fail++; $display("[TB] FAIL long_edge_long: got %0d, expected 0", long_q.size()); end
        n_checks++; if (hold_rise_q.size() !== 0) begin n_fail++; $display("[TB] FAIL long_edge_hold: got %0d, expected 0", hold_rise_q.size()); end
        n_checks++; if (qat(short_q, 0) !== p + 30) begin n_fail++; $display("[TB] FAIL long_edge_short: got %0d, expected %0d", qat(short_q, 0), p + 30); end
    endtask

    task automatic test_both_strobes();
        int p;
        clear_log();
        p = edge_cnt + 2;
        strobe(1'b1, 1'b1, p);
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("[TB] FAIL both_state: got %0d, expected 0", state_o); end
        wait_until(p + 30);
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("[TB] FAIL both_state_later: got %0d, expected 0", state_o); end
        n_checks++; if (short_q.size() + long_q.size() + repeat_q.size() + double_q.size() + hold_rise_q.size() !== 0) begin n_fail++; $display("[TB] FAIL both_outputs: got %0d events, expected 0", short_q.size() + long_q.size() + repeat_q.size() + double_q.size() + hold_rise_q.size()); end
    endtask

    task automatic test_reset_mid_held();
        int p;
        clear_log();
        p = edge_cnt + 2;
        strobe(1'b1, 1'b0, p);
        wait_until(p + 23);
        n_checks++; if (hold_o !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_held_hold: got %b, expected 1", hold_o); end
        arst_n = 1'b0;
        step();
        n_checks++; if (hold_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_held_hold: got %b, expected 0", hold_o); end
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("[TB] FAIL rst_held_state: got %0d, expected 0", state_o); end
        arst_n = 1'b1;
        clear_log();
        p = edge_cnt + 2;
        strobe(1'b1, 1'b0, p);
        strobe(1'b0, 1'b1, p + 3);
        wait_until(p + 25);
        n_checks++; if (qat(short_q, 0) !== p + 13) begin n_fail++; $display("[TB] FAIL post_rst_short: got %0d, expected %0d", qat(short_q, 0), p + 13); end
        n_checks++; if (long_q.size() + repeat_q.size() + double_q.size() !== 0) begin n_fail++; $display("[TB] FAIL post_rst_other: got %0d, expected 0", long_q.size() + repeat_q.size() + double_q.size()); end
    endtask

    // Run every scenario in order and report.
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        arst_n    = 1'b0;
        sw_down_i = 1'b0;
        sw_up_i   = 1'b0;
        $display("[TB] starting button_press_classifier bench");
        test_reset();
        test_short_press();
        test_long_repeat();
        test_double_press();
        test_gap_boundary();
        test_long_boundary();
        test_both_strobes();
        test_reset_mid_held();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
